// File: rtl/sram_ctrl_pkg.sv
// Shared types and helpers for the SRAM controller.
// The byte-merge helper is only used when SRAM_CTRL_RMW_EN is defined.
package sram_ctrl_pkg;

    localparam int SRAM_AW = 16;
    localparam int SRAM_DW = 32;
    localparam int SRAM_BE = SRAM_DW / 8;

    typedef enum logic [2:0] {
        IDLE,
        WSETUP,
        WPULSE,
        RD,
        FIN
    } state_t;

    // Each set mask bit selects the matching byte of new_word; the other bytes come from old_word.
    function automatic logic [SRAM_DW-1:0] byte_merge(
        input logic [SRAM_DW-1:0] old_word,
        input logic [SRAM_DW-1:0] new_word,
        input logic [SRAM_BE-1:0] mask
    );
        logic [SRAM_DW-1:0] merged;
        merged = old_word;
        for (int i = 0; i < SRAM_BE; i++) begin
            if (mask[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/sram_ctrl_if.sv
// Core-side single-word request/completion bus of the SRAM controller.
// WMASK exists only when SRAM_CTRL_RMW_EN is defined.
interface sram_ctrl_if;
    import sram_ctrl_pkg::*;

    logic               REQ;
    logic               WR;
    logic [SRAM_AW-1:0] ADDR;
    logic [SRAM_DW-1:0] WDATA;
`ifdef SRAM_CTRL_RMW_EN
    logic [SRAM_BE-1:0] WMASK;
`endif
    logic               BUSY;
    logic               DONE;
    logic [SRAM_DW-1:0] RDATA;

    modport master (
`ifdef SRAM_CTRL_RMW_EN
        output WMASK,
`endif
        output REQ, WR, ADDR, WDATA,
        input  BUSY, DONE, RDATA
    );

    modport slave (
`ifdef SRAM_CTRL_RMW_EN
        input  WMASK,
`endif
        input  REQ, WR, ADDR, WDATA,
        output BUSY, DONE, RDATA
    );

endinterface

// File: rtl/sram_ctrl.sv
// Sequences registered ADDR/N_WE/N_OE/data strobes for an asynchronous 64K x 32 SRAM.
// Define SRAM_CTRL_RMW_EN to add byte-masked writes done as read-modify-write.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int WE_CYCLES = 2,
    parameter int RD_CYCLES = 2
) (
    input  logic               CLK,
    input  logic               N_RST,
    sram_ctrl_if.slave         bus,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_N_WE,
    output logic               SRAM_N_OE,
    output logic [SRAM_DW-1:0] SRAM_DOUT,
    input  logic [SRAM_DW-1:0] SRAM_DIN
);

    localparam int MAX_CYCLES = (WE_CYCLES > RD_CYCLES) ? WE_CYCLES : RD_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] WE_LOAD = CNT_W'(WE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_CYCLES - 1);

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic               accept;
    logic               capture;
    logic [SRAM_DW-1:0] rdata_q;
`ifdef SRAM_CTRL_RMW_EN
    logic               rmw_q;
    logic [SRAM_BE-1:0] mask_q;
`endif

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.REQ) begin
                    accept = 1'b1;
`ifdef SRAM_CTRL_RMW_EN
                    if (bus.WR && bus.WMASK == '0) begin
                        state_next = FIN;
                    end else if (bus.WR && bus.WMASK == '1) begin
                        state_next = WSETUP;
                    end else begin
                        state_next = RD;
                        cnt_next   = RD_LOAD;
                    end
`else
                    if (bus.WR) begin
                        state_next = WSETUP;
                    end else begin
                        state_next = RD;
                        cnt_next   = RD_LOAD;
                    end
`endif
                end
            end
            WSETUP: begin
                state_next = WPULSE;
                cnt_next   = WE_LOAD;
            end
            WPULSE: begin
                if (cnt == '0) state_next = FIN;
                else           cnt_next   = cnt - CNT_W'(1);
            end
            RD: begin
                if (cnt == '0) begin
                    capture = 1'b1;
`ifdef SRAM_CTRL_RMW_EN
                    state_next = rmw_q ? WSETUP : FIN;
`else
                    state_next = FIN;
`endif
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Strobes are registered from the next state, so they change cleanly on the clock edge.
    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments keep every register updating from pre-edge values.
        if (N_RST) begin
            state     <= IDLE;
            cnt       <= '0;
            SRAM_ADDR <= '0;
            SRAM_DOUT <= '0;
            SRAM_N_WE <= 1'b1;
            SRAM_N_OE <= 1'b1;
            rdata_q   <= '0;
`ifdef SRAM_CTRL_RMW_EN
            rmw_q     <= 1'b0;
            mask_q    <= '0;
`endif
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            SRAM_N_WE <= (state_next != WPULSE);
            SRAM_N_OE <= (state_next != RD);
            if (accept) begin
                SRAM_ADDR <= bus.ADDR;
                SRAM_DOUT <= bus.WDATA;
`ifdef SRAM_CTRL_RMW_EN
                rmw_q     <= bus.WR && (bus.WMASK != '0) && (bus.WMASK != '1);
                mask_q    <= bus.WMASK;
`endif
            end
            if (capture) begin
`ifdef SRAM_CTRL_RMW_EN
                // A masked write reuses the read phase; its result feeds the write, not RDATA.
                if (rmw_q) SRAM_DOUT <= byte_merge(SRAM_DIN, SRAM_DOUT, mask_q);
                else       rdata_q   <= SRAM_DIN;
`else
                rdata_q <= SRAM_DIN;
`endif
            end
        end
    end

    assign bus.BUSY  = (state != IDLE);
    assign bus.DONE  = (state == FIN);
    assign bus.RDATA = rdata_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Scoreboard bench for sram_ctrl: random and directed traffic against an SRAM model.
// Expected responses come from a word-level reference memory and latency rules.
module tb_sram_ctrl;
    import sram_ctrl_pkg::*;

    localparam int T_WE = 2;
    localparam int T_RD = 2;

    logic        clk = 1'b0;
    logic        N_RST;
    logic [15:0] SRAM_ADDR;
    logic        SRAM_N_WE, SRAM_N_OE;
    logic [31:0] SRAM_DOUT, SRAM_DIN;
    logic [31:0] sram_mem [0:65535];

    always #5 clk = ~clk;

    sram_ctrl_if bus ();

    sram_ctrl #(.WE_CYCLES(T_WE), .RD_CYCLES(T_RD)) dut (
        .CLK(clk), .N_RST(N_RST), .bus(bus.slave),
        .SRAM_ADDR(SRAM_ADDR), .SRAM_N_WE(SRAM_N_WE), .SRAM_N_OE(SRAM_N_OE),
        .SRAM_DOUT(SRAM_DOUT), .SRAM_DIN(SRAM_DIN)
    );

    // Asynchronous SRAM: latches on the falling edge of N_WE, drives data only while N_OE is low.
    always @(negedge SRAM_N_WE) sram_mem[SRAM_ADDR] <= SRAM_DOUT;
    assign SRAM_DIN = SRAM_N_OE ? 32'h0 : sram_mem[SRAM_ADDR];

    int checks   = 0;
    int failures = 0;
    int ecount   = 0;
    int sweep_go = 0;
    int sweep_done = 0;

    always @(posedge clk) ecount <= ecount + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        is_wr;
        logic [15:0] addr;
        logic [31:0] data;
        logic [31:0] rdata;
        int          lat;
        int          done_at;
        int          we_low;
        int          oe_low;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] ref_mem [int];
    logic [31:0] last_rd = 32'h0;

    function automatic logic [31:0] ref_rd(input logic [15:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'h0;
    endfunction

    // Reference model: word memory plus latency/strobe-width rules of each transaction kind.
    task automatic predict(input logic wr, input logic [15:0] a, input logic [31:0] d,
                           input logic [3:0] m, input int acc, output exp_t e);
        logic [31:0] old_w, new_w;
        old_w    = ref_rd(a);
        e.is_wr  = wr;
        e.addr   = a;
        e.we_low = 0;
        e.oe_low = 0;
        if (!wr) begin
            e.lat = T_RD + 1; e.oe_low = T_RD; e.data = old_w; last_rd = old_w;
        end else if (m == 4'h0) begin
            e.lat = 1; e.data = d;
        end else if (m == 4'hF) begin
            e.lat = T_WE + 2; e.we_low = T_WE; e.data = d; ref_mem[int'(a)] = d;
        end else begin
            new_w = old_w;
            for (int i = 0; i < 4; i++) if (m[i]) new_w[8*i +: 8] = d[8*i +: 8];
            e.lat = T_RD + T_WE + 2; e.we_low = T_WE; e.oe_low = T_RD;
            e.data = new_w; ref_mem[int'(a)] = new_w;
        end
        e.rdata   = last_rd;
        e.done_at = acc + e.lat - 1;
    endtask

    // Monitor: strobe exclusivity every cycle, scoreboard pop on every DONE.
    int we_cnt = 0;
    int oe_cnt = 0;
    always @(negedge clk) begin : monitor
        exp_t e;
        check("strobe_exclusive", 64'(SRAM_N_WE | SRAM_N_OE), 64'd1);
        if (N_RST) begin
            we_cnt = 0;
            oe_cnt = 0;
        end else begin
            if (!SRAM_N_WE) we_cnt++;
            if (!SRAM_N_OE) oe_cnt++;
        end
        if (bus.DONE === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("done_cycle", 64'(ecount), 64'(e.done_at));
                check("n_we_low_cycles", 64'(we_cnt), 64'(e.we_low));
                check("n_oe_low_cycles", 64'(oe_cnt), 64'(e.oe_low));
                check("sram_addr", 64'(SRAM_ADDR), 64'(e.addr));
                check("rdata", 64'(bus.RDATA), 64'(e.rdata));
                if (e.is_wr) check("sram_dout", 64'(SRAM_DOUT), 64'(e.data));
            end
            we_cnt = 0;
            oe_cnt = 0;
        end
    end

    task automatic wait_idle();
        int guard = 0;
        while (bus.BUSY !== 1'b0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check("idle_timeout", 64'd1, 64'd0);
    endtask

    task automatic issue(input logic wr, input logic [15:0] a, input logic [31:0] d, input logic [3:0] m);
        exp_t e;
        wait_idle();
        bus.REQ = 1'b1; bus.WR = wr; bus.ADDR = a; bus.WDATA = d;
`ifdef SRAM_CTRL_RMW_EN
        bus.WMASK = m;
`endif
        predict(wr, a, d, m, ecount + 1, e);
        sb.push_back(e);
        @(negedge clk);
        bus.REQ = 1'b0;
    endtask

    // REQ stays high; the model predicts each acceptance from the previous latency alone.
    task automatic held_req(input int n);
        int          next_acc, k, guard;
        logic        wr_t;
        logic [15:0] a;
        logic [31:0] d;
        exp_t        e;
        wait_idle();
`ifdef SRAM_CTRL_RMW_EN
        bus.WMASK = 4'hF;
`endif
        next_acc = ecount + 1;
        k = 0;
        guard = 0;
        bus.REQ = 1'b1;
        while (k < n && guard < 2000) begin
            wr_t = 1'($urandom_range(0, 1));
            a    = 16'h0200 + 16'($urandom_range(0, 3));
            d    = $urandom;
            bus.WR = wr_t; bus.ADDR = a; bus.WDATA = d;
            if (ecount + 1 == next_acc) begin
                predict(wr_t, a, d, 4'hF, next_acc, e);
                sb.push_back(e);
                next_acc += e.lat + 1;
                k++;
            end
            @(negedge clk);
            guard++;
        end
        bus.REQ = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (sb.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("drain_pending", 64'(sb.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin : main
        logic [3:0] m;
        bus.REQ = 1'b0; bus.WR = 1'b0; bus.ADDR = '0; bus.WDATA = '0;
`ifdef SRAM_CTRL_RMW_EN
        bus.WMASK = 4'hF;
`endif
        for (int i = 0; i < 65536; i++) sram_mem[i] = 32'h0;

        N_RST = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        N_RST = 1'b0;
        @(negedge clk);
        check("rst_n_we", 64'(SRAM_N_WE), 64'd1);
        check("rst_n_oe", 64'(SRAM_N_OE), 64'd1);
        check("rst_busy", 64'(bus.BUSY), 64'd0);
        check("rst_done", 64'(bus.DONE), 64'd0);
        check("rst_rdata", 64'(bus.RDATA), 64'd0);
        check("rst_sram_addr", 64'(SRAM_ADDR), 64'd0);
        check("rst_sram_dout", 64'(SRAM_DOUT), 64'd0);

        issue(1'b1, 16'h1234, 32'hDEADBEEF, 4'hF);
        issue(1'b0, 16'h1234, 32'h0, 4'hF);

        repeat (40) begin
`ifdef SRAM_CTRL_RMW_EN
            m = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
`else
            m = 4'hF;
`endif
            issue(1'($urandom_range(0, 1)), 16'h0100 + 16'($urandom_range(0, 7)), $urandom, m);
        end

        held_req(12);
        drain();

        // Reset during the second WPULSE cycle: the write is already in the SRAM.
        bus.REQ = 1'b1; bus.WR = 1'b1; bus.ADDR = 16'h0BAD; bus.WDATA = 32'hCAFEF00D;
`ifdef SRAM_CTRL_RMW_EN
        bus.WMASK = 4'hF;
`endif
        ref_mem[int'(16'h0BAD)] = 32'hCAFEF00D;
        @(negedge clk);
        bus.REQ = 1'b0;
        repeat (2) @(negedge clk);
        check("wpulse_n_we_low", 64'(SRAM_N_WE), 64'd0);
        N_RST = 1'b1;
        @(negedge clk);
        check("abort_w_n_we", 64'(SRAM_N_WE), 64'd1);
        check("abort_w_busy", 64'(bus.BUSY), 64'd0);
        check("abort_w_done", 64'(bus.DONE), 64'd0);
        @(negedge clk);
        N_RST = 1'b0;
        last_rd = 32'h0;
        issue(1'b0, 16'h0BAD, 32'h0, 4'hF);
        drain();

        // Reset during RD clears RDATA.
        bus.REQ = 1'b1; bus.WR = 1'b0; bus.ADDR = 16'h1234;
        @(negedge clk);
        bus.REQ = 1'b0;
        check("rd_n_oe_low", 64'(SRAM_N_OE), 64'd0);
        N_RST = 1'b1;
        @(negedge clk);
        check("abort_r_rdata", 64'(bus.RDATA), 64'd0);
        check("abort_r_n_oe", 64'(SRAM_N_OE), 64'd1);
        check("abort_r_busy", 64'(bus.BUSY), 64'd0);
        @(negedge clk);
        N_RST = 1'b0;
        last_rd = 32'h0;
        issue(1'b0, 16'h1234, 32'h0, 4'hF);

`ifdef SRAM_CTRL_RMW_EN
        issue(1'b1, 16'h0000, 32'h11223344, 4'hF);
        issue(1'b1, 16'h0000, 32'hAABBCCDD, 4'b0101);
        issue(1'b1, 16'h0000, 32'h55555555, 4'h0);
        issue(1'b0, 16'h0000, 32'h0, 4'hF);
`endif
        drain();

        for (int g = 0; g < 2; g++) begin
            int guard = 0;
            sweep_go = g + 1;
            while (sweep_done != g + 1 && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            check("sweep_finished", 64'(sweep_done), 64'(g + 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Strobe-width and latency sweep on extra instances with non-default timing.
    for (genvar g = 0; g < 2; g++) begin : sweep
        localparam int SW_WE = (g == 0) ? 1 : 5;
        localparam int SW_RD = (g == 0) ? 4 : 1;

        sram_ctrl_if sbus ();
        logic [15:0] s_addr;
        logic        s_nwe, s_noe;
        logic [31:0] s_dout, s_din, smem;

        sram_ctrl #(.WE_CYCLES(SW_WE), .RD_CYCLES(SW_RD)) u_sw (
            .CLK(clk), .N_RST(N_RST), .bus(sbus.slave),
            .SRAM_ADDR(s_addr), .SRAM_N_WE(s_nwe), .SRAM_N_OE(s_noe),
            .SRAM_DOUT(s_dout), .SRAM_DIN(s_din)
        );

        always @(negedge s_nwe) smem <= s_dout;
        assign s_din = s_noe ? 32'h0 : smem;

        initial begin : sweep_run
            int          nwe, noe, done_n;
            logic [31:0] d;
            sbus.REQ = 1'b0; sbus.WR = 1'b0; sbus.ADDR = 16'h0042; sbus.WDATA = '0;
`ifdef SRAM_CTRL_RMW_EN
            sbus.WMASK = 4'hF;
`endif
            d = $urandom;
            wait (sweep_go == g + 1);
            for (int t = 0; t < 2; t++) begin
                @(negedge clk);
                sbus.REQ = 1'b1; sbus.WR = (t == 0); sbus.WDATA = d;
                nwe = 0; noe = 0; done_n = -1;
                @(negedge clk);
                sbus.REQ = 1'b0;
                for (int n = 0; n < 16; n++) begin
                    if (!s_nwe) nwe++;
                    if (!s_noe) noe++;
                    if (sbus.DONE && done_n < 0) done_n = n + 1;
                    @(negedge clk);
                end
                check("sweep_n_we_low", 64'(nwe), 64'((t == 0) ? SW_WE : 0));
                check("sweep_n_oe_low", 64'(noe), 64'((t == 0) ? 0 : SW_RD));
                check("sweep_done_cycle", 64'(done_n), 64'((t == 0) ? SW_WE + 2 : SW_RD + 1));
            end
            check("sweep_rdata", 64'(sbus.RDATA), 64'(d));
            sweep_done = g + 1;
        end
    end

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Clocked initiator that drives the asynchronous 64K x 32 SRAM: ADDR, N_WE, N_OE, write data out, read data in.
- Converts single-word REQ/DONE transactions from the core bus side into correctly sequenced SRAM strobes.
- Sits between the core's memory port and the SRAM instance.
- All SRAM-side outputs are registered and glitch-free; the SRAM latches data on the falling edge of N_WE.

Parameters:
- WE_CYCLES, 2: cycles N_WE is held low per write; must be >= 1.
- RD_CYCLES, 2: cycles N_OE is held low before read data is captured; must be >= 1.

Ports:
- CLK  in  1  clock; all state changes on posedge.
- N_RST  in  1  reset; synchronous, active-high.
- REQ  in  1  transaction request; sampled only in IDLE.
- WR  in  1  1 = write, 0 = read; sampled with REQ.
- ADDR  in  16  word address; sampled with REQ.
- WDATA  in  32  write data; sampled with REQ.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  single-cycle completion pulse.
- RDATA  out  32  read result; valid from DONE until the next read capture.
- SRAM_ADDR  out  16  to SRAM ADDR.
- SRAM_N_WE  out  1  to SRAM N_WE.
- SRAM_N_OE  out  1  to SRAM N_OE.
- SRAM_DOUT  out  32  to SRAM IN_DATA.
- SRAM_DIN  in  32  from SRAM OUT_DATA.

Behaviour:
- Reset (N_RST=1 at posedge): state IDLE, SRAM_N_WE=1, SRAM_N_OE=1, DONE=0, BUSY=0, RDATA=0, SRAM_ADDR=0, SRAM_DOUT=0.
- States: IDLE, WSETUP, WPULSE, RD, FIN.
- IDLE + REQ:
  - Latch ADDR into SRAM_ADDR and WDATA into SRAM_DOUT.
  - Go to WSETUP if WR=1, else RD.
  - REQ is ignored whenever BUSY=1, including during FIN.
- WSETUP, 1 cycle: N_WE=1 with address and data already stable, giving setup time before the falling edge. Next state WPULSE.
- WPULSE, WE_CYCLES cycles: N_WE=0; a counter counts down. Next state FIN, where N_WE returns to 1.
- RD, RD_CYCLES cycles: N_OE=0. On the edge leaving the last RD cycle, RDATA <= SRAM_DIN and N_OE <= 1. Next state FIN.
- FIN, 1 cycle: DONE=1, all strobes high. Next state IDLE.
- Latency, with acceptance at edge 0:
  - Write: DONE high in cycle WE_CYCLES+2 (4 at defaults).
  - Read: DONE high in cycle RD_CYCLES+1 (3 at defaults).
  - Back-to-back throughput: one transaction per latency+1 cycles.
- Invariant: SRAM_N_WE and SRAM_N_OE are never both 0 in any cycle.
- SRAM_ADDR and SRAM_DOUT change only on REQ acceptance. They are stable throughout WSETUP, WPULSE and FIN.
- Reset mid-operation:
  - The FSM is forced to IDLE and strobes go high on that edge; DONE is not issued.
  - If reset lands during WPULSE, the SRAM has already latched the data on the falling edge, so the write is complete in memory.
  - If reset lands during RD, RDATA is cleared to 0.
- Counter width: $clog2(max(WE_CYCLES,RD_CYCLES)+1). The counter never wraps.

Optional Feature:
- Macro: SRAM_CTRL_RMW_EN.
- Defined:
  - Adds input WMASK [3:0] (byte enables, bit i covers byte i), sampled with REQ.
  - Write with WMASK=4'hF: normal write path, unchanged latency.
  - Write with WMASK in 4'h1..4'hE: perform the RD phase first (RD_CYCLES), merge SRAM_DIN with WDATA per byte into SRAM_DOUT, then WSETUP/WPULSE/FIN. DONE arrives in cycle RD_CYCLES+WE_CYCLES+2.
  - RDATA is unchanged by RMW writes.
  - WMASK=0: go straight to FIN with no strobes; DONE in cycle 1.
- Undefined: no WMASK port; every write is a full 32-bit write.

Decomposition:
- Package sram_ctrl_pkg holds:
  - state enum type (IDLE, WSETUP, WPULSE, RD, FIN);
  - byte-merge function (old, new, mask) -> word;
  - constant SRAM_AW=16 and SRAM_DW=32.
- No sub-module. The FSM and counter stay in one module; the merge is a package function.

Test Plan:
- Reset held 3 cycles, then released → all strobes 1, BUSY=0, DONE=0, RDATA=0.
- Write ADDR=16'h1234, WDATA=32'hDEADBEEF, then read 16'h1234:
  - DONE at cycle 4 for the write, with N_WE low in cycles 2-3 only;
  - read DONE at cycle 3 with RDATA=32'hDEADBEEF.
- REQ held high continuously with alternating WR → each REQ accepted only in IDLE; checker confirms N_WE and N_OE are never both 0.
- Reset asserted in the second WPULSE cycle → N_WE=1 next cycle, no DONE; a later read of that address returns the new data.
- Parameter sweep WE_CYCLES=1,5 and RD_CYCLES=1,4 → N_WE low exactly WE_CYCLES cycles, N_OE low exactly RD_CYCLES cycles.
- With SRAM_CTRL_RMW_EN: word 0 = 32'h11223344, write WDATA=32'hAABBCCDD with WMASK=4'b0101 → memory holds 32'h11BB33DD; DONE at cycle RD_CYCLES+WE_CYCLES+2 = 6.
